// File: rtl/crc_stream_gen.sv
// rtl/crc_stream_gen.sv - parametrised streaming CRC generator/checker
//
// Accepts a valid/ready byte-lane stream, folds every kept lane of each
// accepted beat into a Galois LFSR in a single cycle, and on the final beat
// of a message holds the finished CRC until the consumer takes it.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   input beat valid
//   s_ready    out  input beat accepted when s_valid & s_ready
//   s_data     in   beat data, lane 0 = [7:0] first in message order
//   s_keep     in   per-lane enables
//   s_last     in   final beat of message
//   clear      in   synchronous abort (register to INIT, held result dropped)
//   crc_valid  out  result available
//   crc_ready  in   result consumed when crc_valid & crc_ready
//   crc_out    out  final CRC (REFOUT and XOR_OUT applied)
//   crc_ok     out  raw register matched RESIDUE at message end

module crc_stream_gen #(
  parameter int unsigned          CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] INIT       = 16'hFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = 16'h0000,
  parameter bit                   REFIN      = 1'b0,
  parameter bit                   REFOUT     = 1'b0,
  parameter logic [CRC_WIDTH-1:0] RESIDUE    = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [DATA_WIDTH/8-1:0]   s_keep,
  input  logic                      s_last,
  input  logic                      clear,
  output logic                      crc_valid,
  input  logic                      crc_ready,
  output logic [CRC_WIDTH-1:0]      crc_out,
  output logic                      crc_ok
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [CRC_WIDTH-1:0] crc_out_q, crc_out_d;
  logic                 crc_ok_q, crc_ok_d;

  logic                 beat_acc;
  logic [CRC_WIDTH-1:0] raw_next;
  logic [7:0]           lane_byte;
  logic                 fb;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bitrev_crc(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < int'(CRC_WIDTH); i++) begin
      r[i] = v[int'(CRC_WIDTH)-1-i];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over everything, including a last beat
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (s_valid && s_last) state_d = ST_HOLD;
        ST_HOLD:  if (crc_ready)         state_d = ST_HOLD == ST_HOLD ? ST_ACCUM : ST_ACCUM;
        default:                         state_d = ST_ACCUM;
      endcase
    end
  end

  // Output decode: both handshake outputs come straight from the state flop,
  // so there is no combinational path from crc_ready to s_ready.
  always_comb begin
    s_ready   = (state_q == ST_ACCUM);
    crc_valid = (state_q == ST_HOLD);
  end

  // A beat presented alongside clear is discarded even though s_ready is high
  assign beat_acc = s_valid & s_ready & ~clear;

  // Unrolled LFSR over all lanes in message order; lanes with keep=0 pass
  // the register through untouched so sparse keep patterns work.
  always_comb begin
    raw_next  = crc_q;
    lane_byte = '0;
    fb        = 1'b0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (s_keep[l]) begin
        lane_byte = s_data[8*l +: 8];
        if (REFIN) begin
          lane_byte = bitrev8(lane_byte);
        end
        for (int b = 7; b >= 0; b--) begin
          fb       = raw_next[CRC_WIDTH-1] ^ lane_byte[b];
          raw_next = {raw_next[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
      end
    end
  end

  // Working register and result capture. The last beat reloads INIT in the
  // same cycle so the next message can start right after the HOLD bubble.
  always_comb begin
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    crc_ok_d  = crc_ok_q;
    if (clear) begin
      crc_d = INIT;
    end else if (beat_acc) begin
      if (s_last) begin
        crc_d     = INIT;
        crc_out_d = (REFOUT ? bitrev_crc(raw_next) : raw_next) ^ XOR_OUT;
        crc_ok_d  = (raw_next == RESIDUE);
      end else begin
        crc_d = raw_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= INIT;
      crc_out_q <= '0;
      crc_ok_q  <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  assign crc_out = crc_out_q;
  assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc_stream_gen.sv
// tb/tb_crc_stream_gen.sv - directed self-checking bench for crc_stream_gen

module tb_crc_stream_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // d0: CRC-16/CCITT-FALSE, 8-bit beats (defaults)
  logic        d0_s_valid = 0, d0_s_ready, d0_s_last = 0, d0_clear = 0;
  logic [7:0]  d0_s_data = 0;
  logic [0:0]  d0_s_keep = 0;
  logic        d0_crc_valid, d0_crc_ready = 0, d0_crc_ok;
  logic [15:0] d0_crc_out;

  // d1: CRC-32, 32-bit beats
  logic        d1_s_valid = 0, d1_s_ready, d1_s_last = 0, d1_clear = 0;
  logic [31:0] d1_s_data = 0;
  logic [3:0]  d1_s_keep = 0;
  logic        d1_crc_valid, d1_crc_ready = 0, d1_crc_ok;
  logic [31:0] d1_crc_out;

  // d2: CRC-16/ARC, 8-bit beats
  logic        d2_s_valid = 0, d2_s_ready, d2_s_last = 0, d2_clear = 0;
  logic [7:0]  d2_s_data = 0;
  logic [0:0]  d2_s_keep = 0;
  logic        d2_crc_valid, d2_crc_ready = 0, d2_crc_ok;
  logic [15:0] d2_crc_out;

  crc_stream_gen u_d0 (
    .clk(clk), .rst_n(rst_n), .s_valid(d0_s_valid), .s_ready(d0_s_ready),
    .s_data(d0_s_data), .s_keep(d0_s_keep), .s_last(d0_s_last), .clear(d0_clear),
    .crc_valid(d0_crc_valid), .crc_ready(d0_crc_ready), .crc_out(d0_crc_out), .crc_ok(d0_crc_ok)
  );

  crc_stream_gen #(
    .CRC_WIDTH(32), .POLY(32'h04C11DB7), .DATA_WIDTH(32), .INIT(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(32'hC704DD7B)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .s_valid(d1_s_valid), .s_ready(d1_s_ready),
    .s_data(d1_s_data), .s_keep(d1_s_keep), .s_last(d1_s_last), .clear(d1_clear),
    .crc_valid(d1_crc_valid), .crc_ready(d1_crc_ready), .crc_out(d1_crc_out), .crc_ok(d1_crc_ok)
  );

  crc_stream_gen #(
    .CRC_WIDTH(16), .POLY(16'h8005), .DATA_WIDTH(8), .INIT(16'h0000),
    .XOR_OUT(16'h0000), .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(16'h0000)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .s_valid(d2_s_valid), .s_ready(d2_s_ready),
    .s_data(d2_s_data), .s_keep(d2_s_keep), .s_last(d2_s_last), .clear(d2_clear),
    .crc_valid(d2_crc_valid), .crc_ready(d2_crc_ready), .crc_out(d2_crc_out), .crc_ok(d2_crc_ok)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d0_beat(input logic [7:0] b, input logic [0:0] keep, input logic last);
    d0_s_valid = 1'b1; d0_s_data = b; d0_s_keep = keep; d0_s_last = last;
    tick();
    d0_s_valid = 1'b0; d0_s_last = 1'b0; d0_s_data = 8'hA5;
  endtask

  task automatic d2_beat(input logic [7:0] b, input logic last);
    d2_s_valid = 1'b1; d2_s_data = b; d2_s_keep = 1'b1; d2_s_last = last;
    tick();
    d2_s_valid = 1'b0; d2_s_last = 1'b0;
  endtask

  task automatic d0_msg123();
    logic [7:0] b;
    for (int i = 1; i <= 9; i++) begin
      b = 8'h30 + 8'(i);
      d0_beat(b, 1'b1, i == 9);
    end
  endtask

  task automatic d0_consume();
    d0_crc_ready = 1'b1;
    tick();
    d0_crc_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (d0_s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b expected 1", d0_s_ready); end
    checks++; if (d0_crc_valid !== 1'b0) begin failures++; $display("FAIL reset_crc_valid: got %b expected 0", d0_crc_valid); end
    checks++; if (d0_crc_out !== 16'h0000) begin failures++; $display("FAIL reset_crc_out: got %h expected 0000", d0_crc_out); end
    checks++; if (d0_crc_ok !== 1'b0) begin failures++; $display("FAIL reset_crc_ok: got %b expected 0", d0_crc_ok); end
  endtask

  task automatic test_ccitt();
    logic [7:0] b;
    for (int i = 1; i <= 8; i++) begin
      b = 8'h30 + 8'(i);
      d0_beat(b, 1'b1, 1'b0);
    end
    checks++; if (d0_crc_valid !== 1'b0) begin failures++; $display("FAIL ccitt_early_valid: got %b expected 0", d0_crc_valid); end
    d0_beat(8'h39, 1'b1, 1'b1);
    checks++; if (d0_crc_valid !== 1'b1) begin failures++; $display("FAIL ccitt_valid_latency: got %b expected 1", d0_crc_valid); end
    checks++; if (d0_crc_out !== 16'h29B1) begin failures++; $display("FAIL ccitt_crc_out: got %h expected 29b1", d0_crc_out); end
    checks++; if (d0_s_ready !== 1'b0) begin failures++; $display("FAIL ccitt_hold_s_ready: got %b expected 0", d0_s_ready); end
    d0_consume();
    checks++; if (d0_crc_valid !== 1'b0 || d0_s_ready !== 1'b1) begin failures++; $display("FAIL ccitt_release: got valid=%b ready=%b expected valid=0 ready=1", d0_crc_valid, d0_s_ready); end
  endtask

  task automatic test_residue();
    for (int i = 1; i <= 9; i++) d0_beat(8'h30 + 8'(i), 1'b1, 1'b0);
    d0_beat(8'h29, 1'b1, 1'b0);
    d0_beat(8'hB1, 1'b1, 1'b1);
    checks++; if (d0_crc_ok !== 1'b1) begin failures++; $display("FAIL residue_ok: got %b expected 1", d0_crc_ok); end
    checks++; if (d0_crc_out !== 16'h0000) begin failures++; $display("FAIL residue_raw: got %h expected 0000", d0_crc_out); end
    d0_consume();
    // Flipping the final bit flips the last feedback, so raw becomes POLY
    for (int i = 1; i <= 9; i++) d0_beat(8'h30 + 8'(i), 1'b1, 1'b0);
    d0_beat(8'h29, 1'b1, 1'b0);
    d0_beat(8'hB0, 1'b1, 1'b1);
    checks++; if (d0_crc_ok !== 1'b0) begin failures++; $display("FAIL residue_bad_ok: got %b expected 0", d0_crc_ok); end
    checks++; if (d0_crc_out !== 16'h1021) begin failures++; $display("FAIL residue_bad_raw: got %h expected 1021", d0_crc_out); end
    d0_consume();
  endtask

  task automatic test_keep();
    for (int i = 1; i <= 4; i++) d0_beat(8'h30 + 8'(i), 1'b1, 1'b0);
    d0_beat(8'h77, 1'b0, 1'b0);
    for (int i = 5; i <= 9; i++) d0_beat(8'h30 + 8'(i), 1'b1, i == 9);
    checks++; if (d0_crc_out !== 16'h29B1) begin failures++; $display("FAIL keep_skip: got %h expected 29b1", d0_crc_out); end
    d0_consume();
    d0_beat(8'h5A, 1'b0, 1'b1);
    checks++; if (d0_crc_valid !== 1'b1 || d0_crc_out !== 16'hFFFF) begin failures++; $display("FAIL empty_msg: got valid=%b crc=%h expected valid=1 crc=ffff", d0_crc_valid, d0_crc_out); end
    checks++; if (d0_crc_ok !== 1'b0) begin failures++; $display("FAIL empty_ok: got %b expected 0", d0_crc_ok); end
    d0_consume();
  endtask

  task automatic test_crc32();
    d1_s_valid = 1'b1; d1_s_last = 1'b0; d1_s_keep = 4'b1111; d1_s_data = 32'h34333231;
    tick();
    d1_s_data = 32'h38373635;
    tick();
    d1_s_keep = 4'b0001; d1_s_data = 32'hDEADBE39; d1_s_last = 1'b1;
    tick();
    d1_s_valid = 1'b0; d1_s_last = 1'b0;
    checks++; if (d1_crc_valid !== 1'b1 || d1_crc_out !== 32'hCBF43926) begin failures++; $display("FAIL crc32_out: got valid=%b crc=%h expected valid=1 crc=cbf43926", d1_crc_valid, d1_crc_out); end
    d1_crc_ready = 1'b1;
    tick();
    d1_crc_ready = 1'b0;
    checks++; if (d1_crc_valid !== 1'b0) begin failures++; $display("FAIL crc32_release: got %b expected 0", d1_crc_valid); end
  endtask

  task automatic test_arc();
    for (int i = 1; i <= 4; i++) d2_beat(8'h30 + 8'(i), 1'b0);
    d2_s_data = 8'hFF; d2_s_last = 1'b1;
    tick();
    d2_s_last = 1'b0;
    for (int i = 5; i <= 9; i++) d2_beat(8'h30 + 8'(i), i == 9);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (d2_s_ready !== 1'b0 || d2_crc_valid !== 1'b1 || d2_crc_out !== 16'hBB3D) begin
        failures++;
        $display("FAIL arc_hold_%0d: got ready=%b valid=%b crc=%h expected ready=0 valid=1 crc=bb3d", k, d2_s_ready, d2_crc_valid, d2_crc_out);
      end
      tick();
    end
    d2_crc_ready = 1'b1;
    tick();
    d2_crc_ready = 1'b0;
    checks++; if (d2_crc_valid !== 1'b0 || d2_s_ready !== 1'b1) begin failures++; $display("FAIL arc_release: got valid=%b ready=%b expected valid=0 ready=1", d2_crc_valid, d2_s_ready); end
  endtask

  task automatic test_back_to_back();
    int idx = 0, bubbles = 0, cyc = 0, results = 0;
    logic acc;
    d0_crc_ready = 1'b1;
    while (idx < 18 && cyc < 100) begin
      d0_s_valid = 1'b1; d0_s_keep = 1'b1;
      d0_s_data = 8'h31 + 8'(idx % 9);
      d0_s_last = (idx == 8) || (idx == 17);
      acc = d0_s_ready;
      if (!acc) bubbles++;
      tick();
      cyc++;
      if (acc) idx++;
      if (d0_crc_valid === 1'b1) begin
        results++;
        checks++; if (d0_crc_out !== 16'h29B1) begin failures++; $display("FAIL b2b_result_%0d: got %h expected 29b1", results, d0_crc_out); end
      end
    end
    d0_s_valid = 1'b0; d0_s_last = 1'b0;
    checks++; if (idx != 18) begin failures++; $display("FAIL b2b_timeout: got %0d beats expected 18", idx); end
    checks++; if (bubbles != 1) begin failures++; $display("FAIL b2b_bubbles: got %0d expected 1", bubbles); end
    checks++; if (results != 2) begin failures++; $display("FAIL b2b_results: got %0d expected 2", results); end
    tick();
    d0_crc_ready = 1'b0;
    checks++; if (d0_crc_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", d0_crc_valid); end
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 4; i++) d0_beat(8'h30 + 8'(i), 1'b1, 1'b0);
    d0_clear = 1'b1; d0_s_valid = 1'b1; d0_s_data = 8'h35; d0_s_keep = 1'b1; d0_s_last = 1'b1;
    tick();
    d0_clear = 1'b0; d0_s_valid = 1'b0; d0_s_last = 1'b0;
    checks++; if (d0_crc_valid !== 1'b0) begin failures++; $display("FAIL clear_beat_blocked: got %b expected 0", d0_crc_valid); end
    d0_msg123();
    checks++; if (d0_crc_out !== 16'h29B1) begin failures++; $display("FAIL clear_resend: got %h expected 29b1", d0_crc_out); end
    d0_clear = 1'b1;
    tick();
    d0_clear = 1'b0;
    checks++; if (d0_crc_valid !== 1'b0 || d0_s_ready !== 1'b1) begin failures++; $display("FAIL clear_hold_drop: got valid=%b ready=%b expected valid=0 ready=1", d0_crc_valid, d0_s_ready); end
  endtask

  task automatic test_reset_mid();
    logic pulse_seen = 1'b0;
    for (int i = 1; i <= 4; i++) d0_beat(8'h30 + 8'(i), 1'b1, 1'b0);
    d0_s_valid = 1'b1; d0_s_data = 8'h39; d0_s_keep = 1'b1; d0_s_last = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (d0_s_ready !== 1'b1 || d0_crc_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_hs: got ready=%b valid=%b expected ready=1 valid=0", d0_s_ready, d0_crc_valid); end
    checks++; if (d0_crc_out !== 16'h0000 || d0_crc_ok !== 1'b0) begin failures++; $display("FAIL rst_mid_result: got crc=%h ok=%b expected crc=0000 ok=0", d0_crc_out, d0_crc_ok); end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (d0_crc_valid !== 1'b0) pulse_seen = 1'b1;
    end
    rst_n = 1'b1; d0_s_valid = 1'b0; d0_s_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (d0_crc_valid !== 1'b0) pulse_seen = 1'b1;
    end
    checks++; if (pulse_seen !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse: got %b expected 0", pulse_seen); end
    d0_msg123();
    checks++; if (d0_crc_out !== 16'h29B1) begin failures++; $display("FAIL rst_mid_after: got %h expected 29b1", d0_crc_out); end
    d0_consume();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_ccitt();
    test_residue();
    test_keep();
    test_crc32();
    test_arc();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
